// File: rtl/ring_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ring_decoder
//  Description : Receive-side monitor for a one-hot right-rotating ring bus.
//                Samples the ring word when ring_valid is high, decodes it to
//                a binary phase, checks each step against the rotation, locks
//                after LOCK_CNT consecutive good steps, flags one-hot and step
//                errors, and counts full revolutions while locked.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   rising-edge clock
//    reset        in   1   asynchronous reset, active low
//    ring_in      in   N   one-hot ring word
//    ring_valid   in   1   qualifies ring_in
//    phase        out  PW  phase of the last accepted one-hot sample
//    phase_valid  out  1   pulse: phase updated this cycle
//    lock         out  1   high while in LOCKED
//    onehot_err   out  1   pulse: valid sample was zero or multi-hot
//    step_err     out  1   pulse: locked, one-hot, but not the expected word
//    rev_pulse    out  1   pulse: locked good step landed on phase 0
//    rev_count    out  16  wrapping revolution counter
// ============================================================================
module ring_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 3,
  localparam int PW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  ring_in,
  input  logic          ring_valid,
  output logic [PW-1:0] phase,
  output logic          phase_valid,
  output logic          lock,
  output logic          onehot_err,
  output logic          step_err,
  output logic          rev_pulse,
  output logic [15:0]   rev_count
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  state_t        state_q,       state_d;
  logic [N-1:0]  word_q,        word_d;
  logic [3:0]    good_cnt_q,    good_cnt_d;
  logic [PW-1:0] phase_q,       phase_d;
  logic          phase_valid_q, phase_valid_d;
  logic          lock_q,        lock_d;
  logic          onehot_err_q,  onehot_err_d;
  logic          step_err_q,    step_err_d;
  logic          rev_pulse_q,   rev_pulse_d;
  logic [15:0]   rev_count_q,   rev_count_d;

  logic          sample_onehot;
  logic [PW-1:0] sample_phase;
  logic [N-1:0]  expected_word;
  logic          good_step;
  logic [3:0]    good_cnt_inc;

  // Decode: bit 0 is phase 0, then the set bit walks downward from N-1,
  // so phase = (N - idx) mod N.
  always_comb begin
    sample_phase = '0;
    for (int i = 0; i < N; i++) begin
      if (ring_in[i]) begin
        sample_phase = PW'((N - i) % N);
      end
    end
  end

  assign sample_onehot = $onehot(ring_in);
  assign expected_word = {word_q[0], word_q[N-1:1]};
  assign good_step     = sample_onehot && (ring_in == expected_word);
  assign good_cnt_inc  = good_cnt_q + 4'd1;

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    good_cnt_d    = good_cnt_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    onehot_err_d  = 1'b0;
    step_err_d    = 1'b0;
    rev_pulse_d   = 1'b0;
    rev_count_d   = rev_count_q;

    if (ring_valid) begin
      if (!sample_onehot) begin
        // Corrupt word: drop back to hunting, keep the last good phase.
        onehot_err_d = 1'b1;
        state_d      = ST_HUNT;
        good_cnt_d   = '0;
      end else begin
        phase_d       = sample_phase;
        phase_valid_d = 1'b1;
        word_d        = ring_in;
        unique case (state_q)
          ST_HUNT: begin
            good_cnt_d = '0;
            state_d    = ST_VERIFY;
          end
          ST_VERIFY: begin
            if (good_step) begin
              good_cnt_d = good_cnt_inc;
              if (good_cnt_inc == LOCK_TGT) begin
                state_d = ST_LOCKED;
              end
            end else begin
              good_cnt_d = '0;
            end
          end
          ST_LOCKED: begin
            if (good_step) begin
              if (sample_phase == '0) begin
                rev_pulse_d = 1'b1;
                rev_count_d = rev_count_q + 16'd1;
              end
            end else begin
              step_err_d = 1'b1;
              good_cnt_d = '0;
              state_d    = ST_VERIFY;
            end
          end
          default: begin
            state_d    = ST_HUNT;
            good_cnt_d = '0;
          end
        endcase
      end
    end

    lock_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_HUNT;
      word_q        <= '0;
      good_cnt_q    <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      lock_q        <= 1'b0;
      onehot_err_q  <= 1'b0;
      step_err_q    <= 1'b0;
      rev_pulse_q   <= 1'b0;
      rev_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      good_cnt_q    <= good_cnt_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      lock_q        <= lock_d;
      onehot_err_q  <= onehot_err_d;
      step_err_q    <= step_err_d;
      rev_pulse_q   <= rev_pulse_d;
      rev_count_q   <= rev_count_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign lock        = lock_q;
  assign onehot_err  = onehot_err_q;
  assign step_err    = step_err_q;
  assign rev_pulse   = rev_pulse_q;
  assign rev_count   = rev_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_decoder
//  Description : Self-checking bench for ring_decoder (N=4, LOCK_CNT=3).
//                Directed scenarios followed by randomized traffic, all
//                compared against a phase-arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ring_decoder;

  localparam int N    = 4;
  localparam int LOCK = 3;
  localparam int PW   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  ring_in;
  logic          ring_valid;
  logic [PW-1:0] phase;
  logic          phase_valid;
  logic          lock;
  logic          onehot_err;
  logic          step_err;
  logic          rev_pulse;
  logic [15:0]   rev_count;

  always #5 clk = ~clk;

  ring_decoder #(.N(N), .LOCK_CNT(LOCK)) dut (
    .clk         (clk),
    .reset       (reset),
    .ring_in     (ring_in),
    .ring_valid  (ring_valid),
    .phase       (phase),
    .phase_valid (phase_valid),
    .lock        (lock),
    .onehot_err  (onehot_err),
    .step_err    (step_err),
    .rev_pulse   (rev_pulse),
    .rev_count   (rev_count)
  );

  // Reference model: tracks the ring purely as a phase number.
  // A good step is "phase advanced by exactly one (mod N)".
  bit m_hunting;
  bit m_locked;
  int m_run;
  int m_last;
  int m_phase;
  int m_rev;
  bit e_pv, e_oh, e_se, e_rp;

  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic logic [N-1:0] word_of_phase(int p);
    logic [N-1:0] w;
    w = '0;
    w[(N - p) % N] = 1'b1;
    return w;
  endfunction

  task automatic model_reset();
    m_hunting = 1'b1;
    m_locked  = 1'b0;
    m_run     = 0;
    m_last    = 0;
    m_phase   = 0;
    m_rev     = 0;
    e_pv = 0; e_oh = 0; e_se = 0; e_rp = 0;
  endtask

  task automatic model_step(bit v, logic [N-1:0] w);
    int p;
    e_pv = 0; e_oh = 0; e_se = 0; e_rp = 0;
    if (!v) return;
    if ($countones(w) != 1) begin
      e_oh      = 1;
      m_hunting = 1;
      m_locked  = 0;
      m_run     = 0;
      return;
    end
    p = 0;
    for (int i = 0; i < N; i++) if (w[i]) p = (N - i) % N;
    e_pv    = 1;
    m_phase = p;
    if (m_hunting) begin
      m_hunting = 0;
      m_run     = 0;
    end else if (p == (m_last + 1) % N) begin
      if (m_locked) begin
        if (p == 0) begin
          e_rp  = 1;
          m_rev = (m_rev + 1) % 65536;
        end
      end else begin
        m_run++;
        if (m_run == LOCK) m_locked = 1;
      end
    end else begin
      if (m_locked) e_se = 1;
      m_locked = 0;
      m_run    = 0;
    end
    m_last = p;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    chk({tag, ".phase"},       32'(phase),       32'(m_phase));
    chk({tag, ".phase_valid"}, 32'(phase_valid), 32'(e_pv));
    chk({tag, ".lock"},        32'(lock),        32'(m_locked));
    chk({tag, ".onehot_err"},  32'(onehot_err),  32'(e_oh));
    chk({tag, ".step_err"},    32'(step_err),    32'(e_se));
    chk({tag, ".rev_pulse"},   32'(rev_pulse),   32'(e_rp));
    chk({tag, ".rev_count"},   32'(rev_count),   32'(m_rev));
  endtask

  task automatic step(bit v, logic [N-1:0] w, string tag);
    ring_valid = v;
    ring_in    = w;
    @(posedge clk);
    #1;
    model_step(v, w);
    check_all(tag);
  endtask

  // Pull reset low between edges and confirm the outputs clear at once.
  task automatic async_reset(string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int r;
    logic [N-1:0] w;

    reset      = 1'b0;
    ring_valid = 1'b0;
    ring_in    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    // 1: acquire lock
    step(1, 4'b0001, "t1_0001");
    step(1, 4'b1000, "t1_1000");
    step(1, 4'b0100, "t1_0100");
    step(1, 4'b0010, "t1_0010");
    chk("t1_locked", 32'(lock), 32'd1);

    // 2: revolutions while locked
    step(1, 4'b0001, "t2_0001a");
    chk("t2_rev1", 32'(rev_count), 32'd1);
    step(1, 4'b1000, "t2_1000");
    step(1, 4'b0100, "t2_0100");
    step(1, 4'b0010, "t2_0010");
    step(1, 4'b0001, "t2_0001b");
    chk("t2_rev2", 32'(rev_count), 32'd2);

    // 3: skipped step, then relock
    step(1, 4'b0100, "t3_skip");
    chk("t3_step_err", 32'(step_err), 32'd1);
    chk("t3_phase", 32'(phase), 32'd2);
    step(1, 4'b0010, "t3_0010");
    step(1, 4'b0001, "t3_0001");
    step(1, 4'b1000, "t3_1000");
    chk("t3_relock", 32'(lock), 32'd1);

    // 4: non-one-hot words while locked, then relock
    step(1, 4'b0011, "t4_0011");
    step(1, 4'b0000, "t4_0000");
    chk("t4_oh_err", 32'(onehot_err), 32'd1);
    chk("t4_phase_hold", 32'(phase), 32'd1);
    step(1, 4'b0100, "t4_0100");
    step(1, 4'b0010, "t4_0010");
    step(1, 4'b0001, "t4_0001");
    step(1, 4'b1000, "t4_1000");

    // 5: idle gap while locked
    for (int i = 0; i < 5; i++) step(0, 4'b1111, "t5_idle");
    step(1, 4'b0100, "t5_0100");
    step(1, 4'b0010, "t5_0010");
    step(1, 4'b0001, "t5_0001");
    chk("t5_rev3", 32'(rev_count), 32'd3);

    // 6: asynchronous reset mid-operation
    async_reset("t6_reset");
    step(1, 4'b1000, "t6_1000");
    chk("t6_phase1", 32'(phase), 32'd1);
    chk("t6_unlocked", 32'(lock), 32'd0);

    // Randomized traffic, biased toward correct rotation so lock is reached.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 199);
      if (r < 130) begin
        step(1, word_of_phase((m_last + 1) % N), "rnd_next");
      end else if (r < 150) begin
        step(1, word_of_phase($urandom_range(0, N - 1)), "rnd_onehot");
      end else if (r < 165) begin
        w = N'($urandom_range(0, (1 << N) - 1));
        step(1, w, "rnd_any");
      end else if (r < 198) begin
        w = N'($urandom_range(0, (1 << N) - 1));
        step(0, w, "rnd_idle");
      end else begin
        async_reset("rnd_reset");
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
